// File: rtl/fir_share_sched.sv
// Round-robin scheduler sharing one 2-tap Q1.15 MAC across NCH sample streams.
// Optional macro FIR_SAT_EN: saturate the result instead of two's-complement wrap.
module fir_share_sched #(
    parameter int NCH = 4,
    parameter int W   = 16,
    localparam int CW = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [CW-1:0]    cfg_ch,
    input  logic [1:0]       cfg_sel,
    input  logic [W-1:0]     cfg_data,
    input  logic [NCH-1:0]   in_valid,
    input  logic [NCH*W-1:0] in_data,
    output logic [NCH-1:0]   in_ready,
    output logic             out_valid,
    output logic [CW-1:0]    out_ch,
    output logic [W-1:0]     out_data,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        OUT  = 2'd2
    } state_e;

`ifdef FIR_SAT_EN
    localparam logic signed [2*W:0] SAT_MAX = (2*W+1)'((2**(W-1)) - 1);
    localparam logic signed [2*W:0] SAT_MIN = -SAT_MAX - (2*W+1)'(1);
`endif

    state_e               state_q, state_d;
    logic [CW-1:0]        last_q, last_d;
    logic [CW-1:0]        g_q, g_d;
    logic signed [W-1:0]  x_q, x_d;
    logic [W-1:0]         od_q, od_d;
    logic [CW-1:0]        och_q, och_d;
    logic signed [W-1:0]  xd_q [NCH];
    logic signed [W-1:0]  xd_d [NCH];
    logic signed [W-1:0]  b0_q [NCH];
    logic signed [W-1:0]  b0_d [NCH];
    logic signed [W-1:0]  b1_q [NCH];
    logic signed [W-1:0]  b1_d [NCH];

    logic                 gnt_hit_s;
    logic [CW-1:0]        gnt_ch_s;
    logic signed [W-1:0]  b0_g_s, b1_g_s, xd_g_s;
    logic signed [2*W-1:0] p0_s, p1_s;
    logic signed [2*W:0]  sum_s, sh_s;

    // Narrow the shifted sum to W bits (saturating or wrapping).
    function automatic logic [W-1:0] narrow(input logic signed [2*W:0] v);
`ifdef FIR_SAT_EN
        if (v > SAT_MAX) begin
            narrow = {1'b0, {(W-1){1'b1}}};
        end else if (v < SAT_MIN) begin
            narrow = {1'b1, {(W-1){1'b0}}};
        end else begin
            narrow = v[W-1:0];
        end
`else
        narrow = v[W-1:0];
`endif
    endfunction

    // Round-robin search starting just after the last served channel.
    always_comb begin
        gnt_hit_s = 1'b0;
        gnt_ch_s  = '0;
        for (int i = 1; i <= NCH; i++) begin
            if (!gnt_hit_s && in_valid[(int'(last_q) + i) % NCH]) begin
                gnt_hit_s = 1'b1;
                gnt_ch_s  = CW'((int'(last_q) + i) % NCH);
            end else begin
                gnt_hit_s = gnt_hit_s;
            end
        end
    end

    // Shared MAC: full-precision products, floor shift back to Q1.15.
    always_comb begin
        b0_g_s = b0_q[g_q];
        b1_g_s = b1_q[g_q];
        xd_g_s = xd_q[g_q];
        p0_s   = $signed({{W{x_q[W-1]}}, x_q}) * $signed({{W{b0_g_s[W-1]}}, b0_g_s});
        p1_s   = $signed({{W{xd_g_s[W-1]}}, xd_g_s}) * $signed({{W{b1_g_s[W-1]}}, b1_g_s});
        sum_s  = $signed({p0_s[2*W-1], p0_s}) + $signed({p1_s[2*W-1], p1_s});
        sh_s   = sum_s >>> (W - 1);
    end

    // Next-state logic: FSM, context updates and config writes.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        g_d      = g_q;
        x_d      = x_q;
        od_d     = od_q;
        och_d    = och_q;
        xd_d     = xd_q;
        b0_d     = b0_q;
        b1_d     = b1_q;
        in_ready = '0;
        case (state_q)
            IDLE: begin
                if (gnt_hit_s) begin
                    in_ready[gnt_ch_s] = 1'b1;
                    g_d     = gnt_ch_s;
                    x_d     = in_data[int'(gnt_ch_s)*W +: W];
                    state_d = MUL;
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                od_d       = narrow(sh_s);
                och_d      = g_q;
                xd_d[g_q]  = x_q;
                state_d    = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    last_d  = g_q;
                    state_d = IDLE;
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Config applied last so a delay clear beats the MUL write-back.
        if (cfg_we && (int'(cfg_ch) < NCH)) begin
            case (cfg_sel)
                2'd0:    b0_d[cfg_ch] = cfg_data;
                2'd1:    b1_d[cfg_ch] = cfg_data;
                2'd2:    xd_d[cfg_ch] = '0;
                default: b0_d[cfg_ch] = b0_q[cfg_ch];
            endcase
        end else begin
            b0_d = b0_d;
        end
    end

    // State and context registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= CW'(NCH - 1);
            g_q     <= '0;
            x_q     <= '0;
            od_q    <= '0;
            och_q   <= '0;
            for (int k = 0; k < NCH; k++) begin
                xd_q[k] <= '0;
                b0_q[k] <= '0;
                b1_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            g_q     <= g_d;
            x_q     <= x_d;
            od_q    <= od_d;
            och_q   <= och_d;
            xd_q    <= xd_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
        end
    end

    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign out_data  = od_q;
    assign out_ch    = och_q;

endmodule

// File: tb/tb_fir_share_sched.sv
// Directed table-driven bench for fir_share_sched (NCH=4, W=16).
module tb_fir_share_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [1:0]  cfg_sel;
    logic [15:0] cfg_data;
    logic [3:0]  in_valid;
    logic [63:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [1:0]  out_ch;
    logic [15:0] out_data;
    logic        out_ready;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          ch;
        logic        wr;
        logic [15:0] b0;
        logic [15:0] b1;
        logic [15:0] x;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [8];

`ifdef FIR_SAT_EN
    localparam logic [15:0] OVF_EXP = 16'h7FFF;
`else
    localparam logic [15:0] OVF_EXP = 16'hFFFC;
`endif

    fir_share_sched #(.NCH(4), .W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_sel   (cfg_sel),
        .cfg_data  (cfg_data),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int ch, input int sel, input logic [15:0] d);
        cfg_we   = 1'b1;
        cfg_ch   = 2'(ch);
        cfg_sel  = 2'(sel);
        cfg_data = d;
        step();
        cfg_we   = 1'b0;
    endtask

    // One full sample transaction from IDLE, checking latency and the result.
    task automatic send(input int ch, input logic [15:0] x, input logic [15:0] exp, input string name);
        in_valid           = 4'b0000;
        in_valid[ch]       = 1'b1;
        in_data[ch*16 +: 16] = x;
        out_ready          = 1'b0;
        #1;
        chk({name, "_rdy"}, 32'(in_ready), 32'(4'b0001 << ch));
        step();
        in_valid = 4'b0000;
        chk({name, "_mul_valid"}, 32'(out_valid), 32'd0);
        chk({name, "_mul_busy"}, 32'(busy), 32'd1);
        step();
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_data"}, 32'(out_data), 32'(exp));
        chk({name, "_ch"}, 32'(out_ch), 32'(ch));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        vecs[0] = '{0, 1'b1, 16'h4000, 16'h2000, 16'h1000, 16'h0800};
        vecs[1] = '{0, 1'b0, 16'h0000, 16'h0000, 16'h2000, 16'h1400};
        vecs[2] = '{1, 1'b1, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFE};
        vecs[3] = '{1, 1'b0, 16'h0000, 16'h0000, 16'h7FFF, OVF_EXP};
        vecs[4] = '{2, 1'b1, 16'h4000, 16'h0000, 16'hFFFF, 16'hFFFF};
        vecs[5] = '{3, 1'b1, 16'hC000, 16'h4000, 16'h2000, 16'hF000};
        vecs[6] = '{3, 1'b0, 16'h0000, 16'h0000, 16'h1000, 16'h0800};
        vecs[7] = '{0, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 16'h07FF};

        rst = 1'b1; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_sel = 2'd0; cfg_data = 16'h0000;
        in_valid = 4'b0000; in_data = 64'h0; out_ready = 1'b0;
        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].wr) begin
                cfg(vecs[i].ch, 0, vecs[i].b0);
                cfg(vecs[i].ch, 1, vecs[i].b1);
            end
            send(vecs[i].ch, vecs[i].x, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Back-pressure: clear ch0 delay, then hold the result for 5 cycles.
        cfg(0, 2, 16'h0000);
        in_valid = 4'b0001; in_data[15:0] = 16'h1000; out_ready = 1'b0;
        step();
        in_valid = 4'b1111;
        step();
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", 32'(out_data), 32'h0800);
            chk("bp_ch", 32'(out_ch), 32'd0);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
            step();
        end
        in_valid = 4'b0000; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_release", 32'(busy), 32'd0);
        send(2, 16'h2000, 16'h1000, "resume");

        // Reset while the MAC cycle is in flight.
        in_valid = 4'b0001; in_data[15:0] = 16'h1000;
        step();
        in_valid = 4'b0000;
        rst = 1'b1;
        #1;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_data", 32'(out_data), 32'd0);
        chk("mrst_ch", 32'(out_ch), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("mrst_no_result", 32'(out_valid), 32'd0);
        end
        cfg(0, 1, 16'h2000);
        send(0, 16'h1000, 16'h0000, "post_rst");

        // Round-robin from a fresh reset with all channels requesting.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        in_valid = 4'b1111; out_ready = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rr%0d_grant", i), 32'(in_ready), 32'(4'b0001 << (i % 4)));
            step();
            chk($sformatf("rr%0d_mul", i), 32'(in_ready), 32'd0);
            step();
            chk($sformatf("rr%0d_ch", i), 32'(out_ch), 32'(i % 4));
            step();
        end
        in_valid = 4'b0000; out_ready = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
